// File: rtl/counter_stim_gen_pkg.sv
// Shared types and helpers for the counter stimulus generator.
// STIM_LFSR_EN adds the data-scramble LFSR step function.
package counter_stim_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 8;
  // x^8+x^6+x^5+x^4+1 expressed as feedback taps on bits 7,5,4,3
  localparam logic [CNT_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    HOLD = 3'd3,
    DOWN = 3'd4,
    DONE = 3'd5
  } stim_state_e;

  // First phase after 'cur' whose length is nonzero, else DONE.
  function automatic stim_state_e next_phase(input stim_state_e cur,
                                             input logic up_nz,
                                             input logic hold_nz,
                                             input logic dn_nz);
    stim_state_e nxt;
    nxt = DONE;
    if (cur == LOAD && up_nz) begin
      nxt = UP;
    end else if ((cur == LOAD || cur == UP) && hold_nz) begin
      nxt = HOLD;
    end else if ((cur == LOAD || cur == UP || cur == HOLD) && dn_nz) begin
      nxt = DOWN;
    end
    return nxt;
  endfunction

`ifdef STIM_LFSR_EN
  function automatic logic [CNT_W-1:0] lfsr_step(input logic [CNT_W-1:0] s);
    return {s[CNT_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
`endif

endpackage

// File: rtl/counter_stim_gen_if.sv
// Control/request bundle between the stimulus generator (master) and the counter side (slave).
interface counter_stim_gen_if
  import counter_stim_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic [LEN_W-1:0] up_len;
  logic [LEN_W-1:0] hold_len;
  logic [LEN_W-1:0] dn_len;
  logic             ld_cnt_;
  logic             updn_cnt;
  logic             count_enb;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] exp_count;

  modport master (
    input  start, load_val, up_len, hold_len, dn_len,
    output ld_cnt_, updn_cnt, count_enb, data_in, busy, done, exp_count
  );

  modport slave (
    output start, load_val, up_len, hold_len, dn_len,
    input  ld_cnt_, updn_cnt, count_enb, data_in, busy, done, exp_count
  );
endinterface

// File: rtl/counter_stim_gen_ref_model.sv
// Cycle-accurate model of the up/down counter value; usable beside the real counter too.
module counter_ref_model
  import counter_stim_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ld_cnt_,
  input  logic             updn_cnt,
  input  logic             count_enb,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] exp_count
);

  logic [WIDTH-1:0] exp_count_q;
  logic [WIDTH-1:0] exp_count_d;

  // Load beats enable; counting wraps modulo 2^WIDTH.
  always_comb begin
    exp_count_d = exp_count_q;
    if (!ld_cnt_) begin
      exp_count_d = data_in;
    end else if (count_enb) begin
      exp_count_d = updn_cnt ? exp_count_q + WIDTH'(1) : exp_count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) exp_count_q <= '0;
    else       exp_count_q <= exp_count_d;
  end

  assign exp_count = exp_count_q;

endmodule

// File: rtl/counter_stim_gen.sv
// Drives LOAD -> UP -> HOLD -> DOWN sequences on the counter controls and tracks the expected count.
// STIM_LFSR_EN: scramble data_in outside LOAD with an LFSR seeded by LFSR_SEED.
module counter_stim_gen
  import counter_stim_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
`ifdef STIM_LFSR_EN
  , parameter logic [CNT_W-1:0] LFSR_SEED = 8'hA5
`endif
) (
  input  logic               clk,
  input  logic               rst_,
  counter_stim_gen_if.master bus
);

  stim_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lv_q, lv_d;
  logic [LEN_W-1:0] up_len_q, up_len_d;
  logic [LEN_W-1:0] hold_len_q, hold_len_d;
  logic [LEN_W-1:0] dn_len_q, dn_len_d;
  logic             ld_cnt_q, ld_cnt_d;
  logic             updn_cnt_q, updn_cnt_d;
  logic             count_enb_q, count_enb_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef STIM_LFSR_EN
  logic [CNT_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`endif

  // Next state, phase counter and registered control values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lv_d       = lv_q;
    up_len_d   = up_len_q;
    hold_len_d = hold_len_q;
    dn_len_d   = dn_len_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = LOAD;
          lv_d       = bus.load_val;
          up_len_d   = bus.up_len;
          hold_len_d = bus.hold_len;
          dn_len_d   = bus.dn_len;
        end
      end
      LOAD: state_d = next_phase(LOAD, |up_len_q, |hold_len_q, |dn_len_q);
      UP, HOLD, DOWN: begin
        if (cnt_q == '0) state_d = next_phase(state_q, |up_len_q, |hold_len_q, |dn_len_q);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter holds len-1 on phase entry and counts down to 0 within the phase.
    if (state_d != state_q) begin
      unique case (state_d)
        UP:      cnt_d = up_len_q - LEN_W'(1);
        HOLD:    cnt_d = hold_len_q - LEN_W'(1);
        DOWN:    cnt_d = dn_len_q - LEN_W'(1);
        default: cnt_d = '0;
      endcase
    end else if (state_q == UP || state_q == HOLD || state_q == DOWN) begin
      cnt_d = cnt_q - LEN_W'(1);
    end

    ld_cnt_d    = (state_d != LOAD);
    count_enb_d = (state_d == UP) || (state_d == DOWN);
    updn_cnt_d  = updn_cnt_q;
    if (state_d == UP)   updn_cnt_d = 1'b1;
    if (state_d == DOWN) updn_cnt_d = 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
`ifdef STIM_LFSR_EN
    data_in_d   = (state_d == LOAD) ? lv_d : WIDTH'(lfsr_q);
`else
    data_in_d   = lv_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lv_q        <= '0;
      up_len_q    <= '0;
      hold_len_q  <= '0;
      dn_len_q    <= '0;
      ld_cnt_q    <= 1'b1;
      updn_cnt_q  <= 1'b0;
      count_enb_q <= 1'b0;
      data_in_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lv_q        <= lv_d;
      up_len_q    <= up_len_d;
      hold_len_q  <= hold_len_d;
      dn_len_q    <= dn_len_d;
      ld_cnt_q    <= ld_cnt_d;
      updn_cnt_q  <= updn_cnt_d;
      count_enb_q <= count_enb_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ld_cnt_   = ld_cnt_q;
  assign bus.updn_cnt  = updn_cnt_q;
  assign bus.count_enb = count_enb_q;
  assign bus.data_in   = data_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  counter_ref_model #(.WIDTH(WIDTH)) u_ref_model (
    .clk       (clk),
    .rst_      (rst_),
    .ld_cnt_   (ld_cnt_q),
    .updn_cnt  (updn_cnt_q),
    .count_enb (count_enb_q),
    .data_in   (data_in_q),
    .exp_count (bus.exp_count)
  );

endmodule

// File: tb/tb_counter_stim_gen.sv
// Scoreboard bench for counter_stim_gen: a per-cycle trace model feeds a queue checked by a monitor.
module tb_counter_stim_gen;
  import counter_stim_pkg::*;

  localparam int unsigned W = CNT_W;

  typedef struct packed {
    logic         ld;
    logic         updn;
    logic         enb;
    logic         busy;
    logic         done;
    logic [W-1:0] cnt;
    logic [W-1:0] din;
  } obs_t;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;

  counter_stim_gen_if #(.WIDTH(W)) bus ();

  counter_stim_gen #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  obs_t         exp_q[$];
  obs_t         mon_e;
  int           checks = 0;
  int           passes = 0;
  bit           check_en = 1'b0;
  logic [W-1:0] m_val = '0;
  logic [W-1:0] m_lv  = '0;
  logic         m_updn = 1'b0;

  function automatic obs_t sample();
    obs_t s;
    s = '{ld: bus.ld_cnt_, updn: bus.updn_cnt, enb: bus.count_enb, busy: bus.busy,
          done: bus.done, cnt: bus.exp_count, din: bus.data_in};
    return s;
  endfunction

  function automatic obs_t idle_obs();
    obs_t s;
    s = '{ld: 1'b1, updn: m_updn, enb: 1'b0, busy: 1'b0, done: 1'b0, cnt: m_val, din: m_lv};
    return s;
  endfunction

  task automatic check_obs(input string name, input obs_t act_in, input obs_t exp_in);
    obs_t a, e;
    a = act_in;
    e = exp_in;
`ifdef STIM_LFSR_EN
    if (e.ld) begin a.din = '0; e.din = '0; end
`endif
    checks++;
    if (a == e) passes++;
    else $display("FAIL %s t=%0t got ld=%b updn=%b enb=%b busy=%b done=%b cnt=%h din=%h required ld=%b updn=%b enb=%b busy=%b done=%b cnt=%h din=%h",
                  name, $time, a.ld, a.updn, a.enb, a.busy, a.done, a.cnt, a.din,
                  e.ld, e.updn, e.enb, e.busy, e.done, e.cnt, e.din);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0t got %h required %h", name, $time, act, exp);
  endtask

  // Monitor: every cycle the outputs must match the next expected trace entry, or idle.
  always @(negedge clk) begin
    if (check_en) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else                  mon_e = idle_obs();
      check_obs("cycle", sample(), mon_e);
    end
  end

  // Expected trace: the start cycle, LOAD, each phase cycle, then DONE.
  task automatic push_seq(input logic [W-1:0] lv, input int u, input int h, input int d);
    obs_t e;
    exp_q.push_back(idle_obs());
    m_lv = lv;
    e = '{ld: 1'b0, updn: m_updn, enb: 1'b0, busy: 1'b1, done: 1'b0, cnt: m_val, din: lv};
    exp_q.push_back(e);
    m_val = lv;
    for (int i = 0; i < u; i++) begin
      m_updn = 1'b1;
      e = '{ld: 1'b1, updn: 1'b1, enb: 1'b1, busy: 1'b1, done: 1'b0, cnt: m_val, din: lv};
      exp_q.push_back(e);
      m_val = m_val + W'(1);
    end
    for (int i = 0; i < h; i++) begin
      e = '{ld: 1'b1, updn: m_updn, enb: 1'b0, busy: 1'b1, done: 1'b0, cnt: m_val, din: lv};
      exp_q.push_back(e);
    end
    for (int i = 0; i < d; i++) begin
      m_updn = 1'b0;
      e = '{ld: 1'b1, updn: 1'b0, enb: 1'b1, busy: 1'b1, done: 1'b0, cnt: m_val, din: lv};
      exp_q.push_back(e);
      m_val = m_val - W'(1);
    end
    e = '{ld: 1'b1, updn: m_updn, enb: 1'b0, busy: 1'b1, done: 1'b1, cnt: m_val, din: lv};
    exp_q.push_back(e);
  endtask

  // Issues a start in the cycle after the next posedge; returns during the LOAD cycle.
  task automatic run(input logic [W-1:0] lv, input int u, input int h, input int d);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.load_val = lv;
    bus.up_len   = 8'(u);
    bus.hold_len = 8'(h);
    bus.dn_len   = 8'(d);
    push_seq(lv, u, h, d);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.load_val = W'($urandom);
    bus.up_len   = 8'($urandom);
    bus.hold_len = 8'($urandom);
    bus.dn_len   = 8'($urandom);
  endtask

  // Stray start pulse with different parameters; must be dropped.
  task automatic stray_start();
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.load_val = 8'h77;
    bus.up_len   = 8'd9;
    bus.hold_len = 8'd9;
    bus.dn_len   = 8'd9;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain t=%0t got %0d entries left required 0", $time, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_ld_cnt_",   32'(bus.ld_cnt_),   32'd1);
    chk("rst_updn_cnt",  32'(bus.updn_cnt),  32'd0);
    chk("rst_count_enb", 32'(bus.count_enb), 32'd0);
    chk("rst_data_in",   32'(bus.data_in),   32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_done",      32'(bus.done),      32'd0);
    chk("rst_exp_count", 32'(bus.exp_count), 32'd0);
    chk("rst_state",     32'(dut.state_q),   32'(IDLE));
    chk("rst_phase_cnt", 32'(dut.cnt_q),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got no finish required finish", $time);
    $fatal(1);
  end

  initial begin
    bus.start    = 1'b0;
    bus.load_val = '0;
    bus.up_len   = '0;
    bus.hold_len = '0;
    bus.dn_len   = '0;

    repeat (2) @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst_ = 1'b1;
`ifdef STIM_LFSR_EN
    @(negedge clk);
    chk("lfsr_first", 32'(bus.data_in), 32'h0000_00A5);
    @(negedge clk);
    chk("lfsr_second", 32'(bus.data_in), 32'h0000_004A);
`endif
    @(posedge clk); #1;
    check_en = 1'b1;

    run(8'h10, 3, 2, 1);                 // basic
    wait_drain();
    run(8'hFE, 3, 0, 4);                 // wrap both ways, HOLD skipped
    wait_drain();
    run(8'h5A, 0, 0, 0);                 // LOAD then DONE
    wait_drain();
    run(8'h40, 6, 2, 3);                 // start during UP is dropped
    stray_start();
    wait_drain();
    run(8'h33, 0, 0, 0);                 // start during DONE is dropped
    stray_start();
    wait_drain();
    run(8'h00, 0, 3, 2);                 // down from zero wraps to FF
    wait_drain();

    for (int k = 0; k < 25; k++) begin
      run(W'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
          int'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0) stray_start();
      wait_drain();
    end

    // Asynchronous reset in the middle of UP
    run(8'h20, 10, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_en = 1'b0;
    rst_ = 1'b0;
    @(negedge clk);
    reset_checks();
    exp_q.delete();
    m_val  = '0;
    m_lv   = '0;
    m_updn = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;

    run(8'hC3, 2, 1, 5);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
